div_result_buffer: RTL
======================

DIV_RESULT_BUFFER -- requirements
Module: div_result_buffer

Interface
REQ-001 Parameter XLEN, default 32: data and PC width.
REQ-002 Parameter TAG_W, default 8: physical register tag width.
REQ-003 Parameter DEPTH, default 8: result entries, power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 issue_fire  in  1  an op is launched into the divider this cycle (the divider's start).
REQ-007 issue_ready  out  1  a credit is free; the issuer may assert issue_fire.
REQ-008 div_done  in  1  divider output valid (done); cannot be stalled.
REQ-009 div_result  in  XLEN  quotient/remainder already selected by the divider.
REQ-010 div_tag  in  TAG_W  destination physical tag (Physical_address_out).
REQ-011 div_pc  in  XLEN  PC of the op.
REQ-012 div_dz_exc  in  1  divide-by-zero flag.
REQ-013 cdb_valid  out  1  head entry present, requesting the common data bus.
REQ-014 cdb_grant  in  1  arbiter accepts the head this cycle.
REQ-015 cdb_result  out  XLEN  head result.
REQ-016 cdb_tag  out  TAG_W  head tag.
REQ-017 cdb_pc  out  XLEN  head PC.
REQ-018 cdb_dz_exc  out  1  head exception flag.
REQ-019 err  out  1  sticky protocol-error flag.

Function
REQ-020 Storage SHALL be a circular FIFO of DEPTH entries {result, tag, pc, dz_exc}, with wr_ptr/rd_ptr wrapping modulo DEPTH and count 0..DEPTH.
REQ-021 On div_done=1 with count<DEPTH, the entry SHALL be written at wr_ptr and wr_ptr SHALL advance.
REQ-022 cdb_valid SHALL equal (count!=0); the cdb_* data outputs SHALL reflect the entry at rd_ptr.
REQ-023 A pop SHALL occur when cdb_valid && cdb_grant, advancing rd_ptr; cdb_grant with cdb_valid=0 SHALL be ignored.
REQ-024 There is no bypass: a write into an empty buffer SHALL appear on cdb_valid the next cycle (1-cycle latency).
REQ-025 A simultaneous write and pop SHALL leave count unchanged; this is also legal when full, since the pop frees the slot in the same edge.
REQ-026 The credit counter `reserved` (0..DEPTH) counts in-flight plus stored ops; issue_ready SHALL equal (reserved<DEPTH).
REQ-027 `reserved` SHALL increment on an accepted issue_fire (issue_ready=1), decrement on a pop, and stay unchanged when both occur.
REQ-028 issue_fire while issue_ready=0 SHALL not change `reserved` and SHALL set err.
REQ-029 div_done while full with no simultaneous pop SHALL drop the entry and set err; FIFO contents SHALL be unchanged.
REQ-030 err, once set, SHALL remain 1 until reset.
REQ-031 Entries SHALL leave in arrival order; result, tag, pc and dz_exc SHALL be passed bit-exact.

Reset
REQ-032 Asserting reset SHALL asynchronously clear wr_ptr, rd_ptr, count, reserved and err.
REQ-033 During and after reset: cdb_valid=0, issue_ready=1, err=0, cdb_* data=0.
REQ-034 Reset mid-operation SHALL discard all stored entries and credits; ops still inside the divider are the owner's responsibility, because the divider pipeline is reset by the same signal.
REQ-035 Storage payload SHALL be cleared on reset so the data outputs read 0 when empty.

Structure
REQ-036 XLEN, TAG_W, DEPTH defaults and the entry record typedef {result, tag, pc, dz_exc} SHALL live in the shared package div_pkg.
REQ-037 The FIFO SHALL be the sub-module div_result_fifo (storage, pointers, count); credit logic and err SHALL stay in the top level.

Verification
REQ-038 Single op: issue_fire; 16 cycles later div_done with result=0x7, tag=0x12, pc=0x400 -> next cycle cdb_valid=1 with the same fields; grant -> cdb_valid=0 and issue_ready=1.
REQ-039 Credit exhaustion: 8 issue_fire with no grant -> issue_ready=0 after the 8th; a 9th fire -> err=1 and reserved stays 8.
REQ-040 Full plus simultaneous events: buffer full, one cycle with div_done and cdb_grant -> count stays 8, order preserved, err=0.
REQ-041 Overflow: force div_done while full with no grant -> entry dropped, err=1, existing 8 entries drain unchanged.
REQ-042 Order and wrap: 20 results, tags 0..19, random grants -> CDB tags 0..19 in order, the dz_exc=1 entry for tag 5 preserved, pointers wrap twice.
REQ-043 Reset mid-stream: reset with 3 entries stored -> cdb_valid=0, issue_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/div_pkg.sv
// Shared widths and the result-entry record for the divider result buffer.
package div_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 8;
  localparam int DEPTH_DEF = 8;

  // Field order here matches the packed layout stored in the FIFO.
  typedef struct packed {
    logic [XLEN_DEF-1:0]  result;
    logic [TAG_W_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]  pc;
    logic                 dz_exc;
  } div_entry_t;

  function automatic int entry_width(input int xlen, input int tag_w);
    return 2 * xlen + tag_w + 1;
  endfunction

endpackage

// File: rtl/div_result_fifo.sv
// Circular FIFO holding divider results until the CDB arbiter takes them.
module div_result_fifo #(
  parameter int W     = div_pkg::entry_width(div_pkg::XLEN_DEF, div_pkg::TAG_W_DEF),
  parameter int DEPTH = div_pkg::DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A push into a full FIFO is legal only when a pop frees the head on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the payload array is reset too, so the head outputs read zero while empty after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_result_buffer.sv
// Buffers divider results for the CDB and hands out issue credits so the
// non-stallable divider can never produce a result with nowhere to go.
module div_result_buffer
  import div_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_fire,
  output logic             issue_ready,
  input  logic             div_done,
  input  logic [XLEN-1:0]  div_result,
  input  logic [TAG_W-1:0] div_tag,
  input  logic [XLEN-1:0]  div_pc,
  input  logic             div_dz_exc,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [XLEN-1:0]  cdb_result,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_pc,
  output logic             cdb_dz_exc,
  output logic             err
);

  localparam int ENTRY_W = entry_width(XLEN, TAG_W);
  localparam int RES_W   = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               accept;
  logic               credit_dec;
  logic               overflow;
  logic               bad_issue;
  logic [RES_W-1:0]   reserved;

  assign wr_data = {div_result, div_tag, div_pc, div_dz_exc};

  div_result_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (div_done),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cdb_valid = !fifo_empty;
  assign {cdb_result, cdb_tag, cdb_pc, cdb_dz_exc} = rd_data;

  assign pop         = cdb_valid && cdb_grant;
  assign issue_ready = (reserved < RES_W'(DEPTH));
  assign accept      = issue_fire && issue_ready;
  assign bad_issue   = issue_fire && !issue_ready;
  assign overflow    = div_done && fifo_full && !pop;
  // A pop without a matching credit (result produced outside the credit scheme) must not underflow.
  assign credit_dec  = pop && (reserved != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reserved <= '0;
      err      <= 1'b0;
    end else begin
      case ({accept, credit_dec})
        2'b10:   reserved <= reserved + 1'b1;
        2'b01:   reserved <= reserved - 1'b1;
        default: reserved <= reserved;
      endcase
      if (bad_issue || overflow) err <= 1'b1;
    end
  end

endmodule
